// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types for the multi-cycle ALU:
//   alu_op_t   - 4-bit operation encodings driven on the ALU 'op' port
//   md_state_t - states of the iterative multiply/divide engine
//   is_md_op() - true for the two ops that launch the engine
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MULT = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_NOT  = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001,
        OP_SLT  = 4'b1010,
        OP_MFLO = 4'b1110,
        OP_MFHI = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Iterative multiply/divide engine that owns the architectural HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on
// operand magnitudes; the sign fixup is folded into the last step.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, op, sign   - launch request, operation select, signed mode
//   a, b              - operands, captured on the accepting edge
//   hi, lo            - architectural HI/LO
//   busy              - engine in RUN
//   done              - one-cycle completion pulse
//   div_by_zero       - set when a divide by zero completes, cleared on next launch
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic         sign,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    md_state_t      state;
    logic [CW-1:0]  count;
    logic           is_div;
    logic           neg_lo;
    logic           neg_hi;
    logic           b_zero;
    logic [N-1:0]   mag;
    logic [N-1:0]   hi_work;
    logic [N-1:0]   lo_work;

    logic           accept;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   abs_a;
    logic [N-1:0]   abs_b;

    logic [N:0]     sum;
    logic [N:0]     shifted;
    logic [N:0]     diff;
    logic [N-1:0]   step_hi;
    logic [N-1:0]   step_lo;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix;
    logic [N-1:0]   rem_fix;

    // The engine is re-armable from IDLE and DONE, never from RUN.
    assign accept = start && is_md_op(op) && (state != MD_RUN);

    // Operand magnitudes; negating MIN wraps back to MIN, which is the
    // correct unsigned magnitude 2^(N-1).
    always_comb begin
        a_neg = sign & a[N-1];
        b_neg = sign & b[N-1];
        abs_a = a_neg ? (~a + 1'b1) : a;
        abs_b = b_neg ? (~b + 1'b1) : b;
    end

    // One iteration of the engine, plus the signed result of the final step.
    // Multiply: {hi_work, lo_work} is the shifting product, multiplier bits
    // consumed from lo_work[0]. Divide: hi_work is the partial remainder,
    // lo_work shifts dividend bits out the top and quotient bits in the bottom.
    always_comb begin
        sum      = {1'b0, hi_work} + (lo_work[0] ? {1'b0, mag} : {(N+1){1'b0}});
        shifted  = {hi_work, lo_work[N-1]};
        diff     = shifted - {1'b0, mag};
        step_hi  = hi_work;
        step_lo  = lo_work;
        if (is_div) begin
            step_hi = diff[N] ? shifted[N-1:0] : diff[N-1:0];
            step_lo = {lo_work[N-2:0], ~diff[N]};
        end else begin
            step_hi = sum[N:1];
            step_lo = {sum[0], lo_work[N-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_lo ? (~prod + 1'b1) : prod;
        quo_fix  = neg_lo ? (~step_lo + 1'b1) : step_lo;
        rem_fix  = neg_hi ? (~step_hi + 1'b1) : step_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MD_IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            b_zero      <= 1'b0;
            mag         <= '0;
            hi_work     <= '0;
            lo_work     <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            state       <= MD_RUN;
            count       <= '0;
            is_div      <= (op == OP_DIV);
            b_zero      <= (b == '0);
            busy        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_work     <= '0;
            if (op == OP_DIV) begin
                // Quotient sign is the XOR of operand signs; remainder follows a.
                neg_lo  <= a_neg ^ b_neg;
                neg_hi  <= a_neg;
                mag     <= abs_b;
                lo_work <= abs_a;
            end else begin
                neg_lo  <= a_neg ^ b_neg;
                neg_hi  <= a_neg ^ b_neg;
                mag     <= abs_a;
                lo_work <= abs_b;
            end
        end else begin
            case (state)
                MD_IDLE: begin
                    done <= 1'b0;
                end
                MD_RUN: begin
                    hi_work <= step_hi;
                    lo_work <= step_lo;
                    if (count == CW'(N - 1)) begin
                        count <= '0;
                        state <= MD_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (is_div && b_zero) begin
                            // HI/LO are left untouched on a divide by zero.
                            div_by_zero <= 1'b1;
                        end else if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*N-1:N];
                            lo <= prod_fix[N-1:0];
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                MD_DONE: begin
                    done  <= 1'b0;
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops plus a
// multi-cycle multiply/divide engine writing HI/LO.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   start              - launch MULT/DIV (ignored while busy or for other ops)
//   op                 - operation select (alu_op_t encodings)
//   sign               - signed mode for add/sub/mult/div/slt
//   a, b               - operands
//   result, zero       - combinational result of op and its zero flag
//   busy, done         - engine handshake for pipeline stalling
//   div_by_zero        - sticky flag from the last divide
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic         sign,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int SW = $clog2(N);

    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic [SW-1:0] shamt;
    logic          lt;
    alu_op_t       op_e;

    assign shamt = b[SW-1:0];
    assign op_e  = alu_op_t'(op);
    assign lt    = sign ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        result = '0;
        case (op_e)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_SLT:  result = {{(N-1){1'b0}}, lt};
            OP_MFLO: result = lo;
            OP_MFHI: result = hi;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    muldiv_seq #(
        .N(N)
    ) u_muldiv_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .sign        (sign),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised N-bit ALU that replaces the single-cycle `alu` in the execute stage. Logic, add/sub, shift and compare ops are single-cycle combinational. Multiply and divide run on an iterative multi-cycle engine that writes architectural HI/LO registers. A start/busy/done handshake lets the control unit stall the pipeline while the engine runs.

## Interface
- `N`, default 32: datapath width, ≥ 4 and a power of two. The shift amount is `b[$clog2(N)-1:0]`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: launch a mult/div. Honoured only when `op` is MULT or DIV and the engine is not in RUN.
- `op` input 4: operation select (encodings in the Operation section).
- `sign` input 1: 1 = signed add/sub/mult/div/slt, 0 = unsigned.
- `a`, `b` input N: operands. Sampled on the accepting edge for mult/div.
- `result` output N: combinational result of `op`.
- `zero` output 1: `result == 0`.
- `busy` output 1: engine in RUN.
- `done` output 1: one-cycle pulse; HI/LO hold the new value during this cycle.
- `div_by_zero` output 1: registered flag.

## Operation
- Op encodings:
  - 0000 ADD, 0001 SUB, 0010 MULT, 0011 DIV.
  - 0100 AND, 0101 OR, 0110 NOT a, 0111 SLL.
  - 1000 SRL, 1001 SRA (new), 1010 SLT (new; signed compare when `sign`=1).
  - 1110 MFLO, 1111 MFHI.
  - Any other encoding gives `result` = 0.
- ADD/SUB wrap modulo 2^N. No overflow flag.
- MULT and DIV drive `result` = 0. Their outputs appear only through MFLO/MFHI.
- MULT: HI:LO = full 2N-bit product.
- DIV: LO = quotient, HI = remainder, truncating toward zero. The remainder takes the sign of `a`.
- Signed MULT/DIV:
  - The engine operates on magnitudes, then negates per sign rules in the final iteration.
  - DIV of MIN / -1 gives LO = MIN, HI = 0.
- DIV with `b` = 0:
  - Runs the full latency and leaves HI/LO unchanged.
  - Sets `div_by_zero` = 1 on entry to DONE.
  - `div_by_zero` is cleared on the next accepted `start`.
- FSM states IDLE, RUN, DONE:
  - IDLE: on `start` with MULT/DIV, latch operands and `sign`, set iteration counter to 0, go to RUN.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle. At count N-1, write HI/LO (with sign fixup) and go to DONE.
  - DONE: `done` = 1. An accepted `start` goes to RUN; otherwise go to IDLE.
- `start` while in RUN is ignored. `start` with any other op is ignored.
- Combinational ops stay valid while busy. MFHI/MFLO during RUN return the previous HI/LO; control must stall on `busy`.

## Timing
- Reset values: state IDLE, counter 0, HI = LO = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0.
- An `rst_n` assertion in RUN aborts immediately. There is no partial HI/LO write.
- Combinational ops have zero-cycle latency.
- MULT/DIV latency, with `start` accepted on edge 0:
  - `busy` = 1 in cycles 1..N.
  - HI/LO are written on edge N.
  - `done` = 1 in cycle N+1.
  - A back-to-back `start` in the DONE cycle gives the next `done` at cycle 2N+2.
- Throughput is one mult/div per N+1 cycles.

## Structure
- Package `alu_pkg`: `alu_op_t` enum (all encodings above) and `md_state_t` enum (IDLE/RUN/DONE).
- Sub-module `muldiv_seq`:
  - Contains the FSM, counter, operand/accumulator registers, HI/LO and the div-by-zero flag.
  - Exposes `hi`, `lo`, `busy`, `done`, `div_by_zero`.
- Top `alu_muldiv`: combinational op mux plus the `muldiv_seq` instance.

## Test plan
- ADD 5+7 → `result` 12, `zero` 0. SUB 7-7 → 0, `zero` 1. SRA -8>>1 → 0xFFFFFFFC. SLT -1<1 → 1 with `sign`=1, 0 with `sign`=0.
- Unsigned MULT 0xFFFFFFFF×2, N=32:
  - `busy` high exactly 32 cycles, `done` in cycle 33.
  - MFHI → 1, MFLO → 0xFFFFFFFE.
- Signed DIV -7/2 → LO 0xFFFFFFFD, HI 0xFFFFFFFF. Signed DIV 0x80000000/-1 → LO 0x80000000, HI 0.
- DIV 10/0 after a prior MULT → `done` at cycle 33, `div_by_zero` 1, HI/LO equal the prior MULT result. The next `start` clears the flag.
- Drop `rst_n` at cycle 10 of a MULT:
  - `busy` drops asynchronously and HI/LO read 0.
  - A new MULT 3×4 gives LO 12.
- `start` pulsed during RUN → no effect on latency or result. `start` in the DONE cycle → accepted; second `done` at cycle 66.
